// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit
// Forwarding and load-use hazard unit for a classic 5-stage pipeline.
// Shadows the destination metadata of the EX, MEM and WB stages internally,
// derives the per-operand ALU forward selects for the EX instruction and
// raises a one-cycle stall (with bubble) when the ID instruction consumes
// the result of a load that is currently in EX.
//
// Record layout:
//   EX  : valid, rd, regwrite, is_load, src[NUM_SRC]
//   MEM : valid, rd, regwrite, is_load
//   WB  : valid, rd, regwrite
// WB's is_load flag and the MEM/WB source ids are never consulted by any
// output, so they are not stored.

module fwd_hazard_unit #(
    parameter int REG_W   = 4,
    parameter int NUM_SRC = 2,
    parameter int CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     id_valid,
    input  logic [REG_W-1:0]         id_rd,
    input  logic                     id_regwrite,
    input  logic                     id_is_load,
    input  logic [NUM_SRC*REG_W-1:0] id_src,
    input  logic                     flush,
    input  logic                     ext_stall,
    output logic [2*NUM_SRC-1:0]     fwd_sel,
    output logic                     hazard_stall,
    output logic [CNT_W-1:0]         stall_count
);

    // ------------------------------------------------------------------
    // Stage records
    // ------------------------------------------------------------------
    // Valid bits are reset; the payload fields are don't-care while the
    // matching valid bit is low, so they carry no reset.
    logic                     ex_valid_reg;
    logic [REG_W-1:0]         ex_rd_reg;
    logic                     ex_regwrite_reg;
    logic                     ex_is_load_reg;
    logic [NUM_SRC*REG_W-1:0] ex_src_reg;

    logic                     mem_valid_reg;
    logic [REG_W-1:0]         mem_rd_reg;
    logic                     mem_regwrite_reg;
    logic                     mem_is_load_reg;

    logic                     wb_valid_reg;
    logic [REG_W-1:0]         wb_rd_reg;
    logic                     wb_regwrite_reg;

    logic [CNT_W-1:0]         stall_count_reg;
    logic [CNT_W-1:0]         stall_count_next;

    // ------------------------------------------------------------------
    // Per-stage qualifiers that do not depend on the register being
    // compared; r0 is hardwired zero and never produces a forward.
    // ------------------------------------------------------------------
    logic ex_load_wr;   // EX holds a load that writes a non-zero register
    logic mem_fwd_ok;   // MEM can supply a forward (non-load writer)
    logic wb_wr_ok;     // WB writes a non-zero register

    assign ex_load_wr = ex_valid_reg & ex_regwrite_reg & ex_is_load_reg
                      & (ex_rd_reg != '0);
    assign mem_fwd_ok = mem_valid_reg & mem_regwrite_reg & ~mem_is_load_reg
                      & (mem_rd_reg != '0);
    assign wb_wr_ok   = wb_valid_reg & wb_regwrite_reg & (wb_rd_reg != '0);

    // ------------------------------------------------------------------
    // Per-operand compares: ID sources against the load in EX, and EX
    // sources against the MEM/WB producers.
    // ------------------------------------------------------------------
    logic [NUM_SRC-1:0] id_src_hit;
    logic [NUM_SRC-1:0] mem_hit;
    logic [NUM_SRC-1:0] wb_hit;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            logic [REG_W-1:0] ex_src_i;
            logic [REG_W-1:0] id_src_i;

            assign ex_src_i = ex_src_reg[gi*REG_W +: REG_W];
            assign id_src_i = id_src[gi*REG_W +: REG_W];

            assign id_src_hit[gi] = (id_src_i == ex_rd_reg);
            assign mem_hit[gi]    = mem_fwd_ok & (mem_rd_reg == ex_src_i);
            assign wb_hit[gi]     = wb_wr_ok   & (wb_rd_reg  == ex_src_i);

            // MEM has priority over WB because it holds the younger value.
            assign fwd_sel[2*gi +: 2] = ~ex_valid_reg ? 2'b00 :
                                        mem_hit[gi]   ? 2'b10 :
                                        wb_hit[gi]    ? 2'b01 :
                                                        2'b00;
        end
    endgenerate

    // A branch flush kills the dependent ID instruction, so it suppresses
    // the stall as well.
    assign hazard_stall = id_valid & ex_load_wr & (|id_src_hit) & ~flush;

    assign stall_count = stall_count_reg;

    // Saturating increment of the stall counter.
    always_comb begin
        stall_count_next = stall_count_reg;
        if (stall_count_reg != '1) begin
            stall_count_next = stall_count_reg + CNT_W'(1);
        end
    end

    // Valid bits and stall counter: cleared on reset, frozen on ext_stall,
    // otherwise shift down the pipe with a bubble on flush or stall.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid_reg    <= 1'b0;
            mem_valid_reg   <= 1'b0;
            wb_valid_reg    <= 1'b0;
            stall_count_reg <= '0;
        end else if (!ext_stall) begin
            wb_valid_reg  <= mem_valid_reg;
            mem_valid_reg <= ex_valid_reg;
            if (flush || hazard_stall) begin
                ex_valid_reg <= 1'b0;
            end else begin
                ex_valid_reg <= id_valid;
            end
            if (hazard_stall) begin
                stall_count_reg <= stall_count_next;
            end
        end
    end

    // Record payloads: load unconditionally whenever the pipe advances;
    // a bubble's payload is never observed because its valid bit is low.
    always_ff @(posedge clk) begin
        if (!ext_stall) begin
            ex_rd_reg        <= id_rd;
            ex_regwrite_reg  <= id_regwrite;
            ex_is_load_reg   <= id_is_load;
            ex_src_reg       <= id_src;

            mem_rd_reg       <= ex_rd_reg;
            mem_regwrite_reg <= ex_regwrite_reg;
            mem_is_load_reg  <= ex_is_load_reg;

            wb_rd_reg        <= mem_rd_reg;
            wb_regwrite_reg  <= mem_regwrite_reg;
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Testbench for fwd_hazard_unit: directed scenarios with literal expectations
// followed by randomized traffic checked every cycle against a pipeline
// model. Two instances share the stimulus: one with a 16-bit counter and one
// with a 2-bit counter so saturation is exercised.

module tb_fwd_hazard_unit;

    localparam int REG_W   = 4;
    localparam int NUM_SRC = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     rst_n;
    logic                     id_valid;
    logic [REG_W-1:0]         id_rd;
    logic                     id_regwrite;
    logic                     id_is_load;
    logic [NUM_SRC*REG_W-1:0] id_src;
    logic                     flush;
    logic                     ext_stall;

    logic [2*NUM_SRC-1:0]     fwd_sel;
    logic                     hazard_stall;
    logic [15:0]              stall_count;
    logic [2*NUM_SRC-1:0]     fwd_sel_s;
    logic                     hazard_stall_s;
    logic [1:0]               stall_count_s;

    fwd_hazard_unit #(.REG_W(REG_W), .NUM_SRC(NUM_SRC), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_is_load(id_is_load), .id_src(id_src),
        .flush(flush), .ext_stall(ext_stall), .fwd_sel(fwd_sel),
        .hazard_stall(hazard_stall), .stall_count(stall_count)
    );

    fwd_hazard_unit #(.REG_W(REG_W), .NUM_SRC(NUM_SRC), .CNT_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_is_load(id_is_load), .id_src(id_src),
        .flush(flush), .ext_stall(ext_stall), .fwd_sel(fwd_sel_s),
        .hazard_stall(hazard_stall_s), .stall_count(stall_count_s)
    );

    // ------------------------------------------------------------------
    // Model: an array of instructions, index 0 = EX, 1 = MEM, 2 = WB
    // ------------------------------------------------------------------
    typedef struct packed {
        logic       v;
        logic [3:0] rd;
        logic       rw;
        logic       ld;
        logic [3:0] s0;
        logic [3:0] s1;
    } instr_t;

    instr_t pipe [3];
    int     model_cnt = 0;
    bit     model_ok  = 1'b0;
    int     passed    = 0;
    int     total     = 0;

    function automatic bit produces(instr_t ins, logic [3:0] r);
        return ins.v && ins.rw && (ins.rd != 4'd0) && (ins.rd == r);
    endfunction

    // Where does the EX instruction get register r from? Walk from the
    // youngest older instruction outward; a load in MEM has no data yet.
    function automatic logic [1:0] src_of(logic [3:0] r);
        if (!pipe[0].v) return 2'b00;
        for (int s = 1; s <= 2; s++) begin
            if (produces(pipe[s], r) && !(s == 1 && pipe[s].ld))
                return (s == 1) ? 2'b10 : 2'b01;
        end
        return 2'b00;
    endfunction

    function automatic logic [3:0] exp_fwd();
        return {src_of(pipe[0].s1), src_of(pipe[0].s0)};
    endfunction

    function automatic bit exp_hz();
        bit uses;
        uses = (id_src[3:0] == pipe[0].rd) || (id_src[7:4] == pipe[0].rd);
        return id_valid && pipe[0].v && pipe[0].ld && pipe[0].rw
               && (pipe[0].rd != 4'd0) && uses && !flush;
    endfunction

    function automatic int sat(int v, int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model state update on each rising edge.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < 3; s++) pipe[s] = '0;
            model_cnt = 0;
            model_ok  = 1'b1;
        end else if (model_ok && !ext_stall) begin
            bit hz;
            hz = exp_hz();
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            if (flush || hz) begin
                pipe[0].v = 1'b0;
                if (hz) model_cnt++;
            end else begin
                pipe[0] = '{v: id_valid, rd: id_rd, rw: id_regwrite,
                            ld: id_is_load, s0: id_src[3:0], s1: id_src[7:4]};
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (model_ok) begin
            bit bad;
            chk("fwd_sel",        32'(fwd_sel),        32'(exp_fwd()));
            chk("fwd_sel_s",      32'(fwd_sel_s),      32'(exp_fwd()));
            chk("hazard_stall",   32'(hazard_stall),   32'(exp_hz()));
            chk("hazard_stall_s", 32'(hazard_stall_s), 32'(exp_hz()));
            chk("stall_count",    32'(stall_count),    32'(sat(model_cnt, 65535)));
            chk("stall_count_s",  32'(stall_count_s),  32'(sat(model_cnt, 3)));
            bad = pipe[0].v && pipe[1].ld &&
                  (produces(pipe[1], pipe[0].s0) || produces(pipe[1], pipe[0].s1));
            chk("no_load_in_mem_dep", 32'(bad), 32'd0);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic idle();
        id_valid = 0; id_rd = 0; id_regwrite = 0; id_is_load = 0;
        id_src = 0; flush = 0; ext_stall = 0;
    endtask

    task automatic set_id(input logic v, input logic [3:0] rd, input logic rw,
                          input logic ld, input logic [3:0] s0, input logic [3:0] s1);
        id_valid = v; id_rd = rd; id_regwrite = rw; id_is_load = ld;
        id_src = {s1, s0};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    initial begin
        rst_n = 0;
        idle();
        step();
        step();
        rst_n = 1;
        settle();
        chk("reset_fwd", 32'(fwd_sel), 32'd0);
        chk("reset_cnt", 32'(stall_count), 32'd0);

        // Back-to-back: add r1 ; sub r2,r1,r1
        set_id(1, 1, 1, 0, 2, 3); step();
        set_id(1, 2, 1, 0, 1, 1); step();
        idle(); settle();
        chk("b2b_fwd", 32'(fwd_sel), 32'h0000000a);
        chk("b2b_hz",  32'(hazard_stall), 32'd0);

        // Distance 2: add r1 ; nop ; or r4,r1,r5
        set_id(1, 1, 1, 0, 2, 3); step();
        idle(); step();
        set_id(1, 4, 1, 0, 1, 5); step();
        idle(); settle();
        chk("dist2_fwd", 32'(fwd_sel), 32'h00000001);

        // MEM and WB both write r1: MEM wins
        set_id(1, 1, 1, 0, 2, 3); step();
        set_id(1, 1, 1, 0, 6, 7); step();
        set_id(1, 4, 1, 0, 1, 5); step();
        idle(); settle();
        chk("memwins_fwd", 32'(fwd_sel), 32'h00000002);

        // Load-use: lw r2 ; add r3,r2,r0
        set_id(1, 2, 1, 1, 8, 9); step();
        set_id(1, 3, 1, 0, 2, 0); settle();
        chk("lu_hz", 32'(hazard_stall), 32'd1);
        chk("lu_cnt0", 32'(stall_count), 32'd0);
        step(); settle();
        chk("lu_hz_drop", 32'(hazard_stall), 32'd0);
        chk("lu_cnt1", 32'(stall_count), 32'd1);
        chk("lu_bubble", 32'(fwd_sel), 32'd0);
        step(); idle(); settle();
        chk("lu_fwd", 32'(fwd_sel), 32'h00000001);

        // r0 destination never forwards
        set_id(1, 0, 1, 0, 2, 3); step();
        set_id(1, 5, 1, 0, 0, 0); step();
        idle(); settle();
        chk("r0_fwd", 32'(fwd_sel), 32'd0);
        // lw r0 never stalls
        set_id(1, 0, 1, 1, 2, 3); step();
        set_id(1, 5, 1, 0, 0, 0); settle();
        chk("lw_r0_hz", 32'(hazard_stall), 32'd0);
        step(); idle();
        // store (no regwrite) does not forward
        set_id(1, 1, 0, 0, 2, 3); step();
        set_id(1, 5, 1, 0, 1, 1); step();
        idle(); settle();
        chk("store_fwd", 32'(fwd_sel), 32'd0);

        // Flush concurrent with load-use
        set_id(1, 5, 1, 1, 2, 3); step();
        set_id(1, 6, 1, 0, 5, 5); flush = 1; settle();
        chk("flush_hz", 32'(hazard_stall), 32'd0);
        step(); idle(); settle();
        chk("flush_cnt", 32'(stall_count), 32'd1);
        chk("flush_bubble", 32'(fwd_sel), 32'd0);

        // ext_stall held three cycles during a load-use hazard
        set_id(1, 7, 1, 1, 2, 3); step();
        set_id(1, 8, 1, 0, 7, 1); ext_stall = 1;
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("frz_hz", 32'(hazard_stall), 32'd1);
            chk("frz_cnt", 32'(stall_count), 32'd1);
            step();
        end
        ext_stall = 0; settle();
        chk("frz_rel_hz", 32'(hazard_stall), 32'd1);
        step(); settle();
        chk("frz_cnt2", 32'(stall_count), 32'd2);
        chk("frz_hz_drop", 32'(hazard_stall), 32'd0);
        step(); idle();

        // Saturation of the 2-bit counter
        set_id(1, 9, 1, 1, 2, 3); step();
        set_id(1, 10, 1, 0, 9, 9); step(); settle();
        chk("sat_cnt3", 32'(stall_count), 32'd3);
        chk("sat_cnt3_s", 32'(stall_count_s), 32'd3);
        step(); idle(); step();
        set_id(1, 9, 1, 1, 2, 3); step();
        set_id(1, 10, 1, 0, 4, 9); step(); settle();
        chk("sat_cnt4", 32'(stall_count), 32'd4);
        chk("sat_hold_s", 32'(stall_count_s), 32'd3);
        step(); idle(); step();

        // Reset asserted mid-stall
        set_id(1, 11, 1, 1, 2, 3); step();
        set_id(1, 12, 1, 0, 11, 11); settle();
        chk("rst_pre_hz", 32'(hazard_stall), 32'd1);
        rst_n = 0; step(); rst_n = 1; settle();
        chk("rst_hz", 32'(hazard_stall), 32'd0);
        chk("rst_fwd", 32'(fwd_sel), 32'd0);
        chk("rst_cnt", 32'(stall_count), 32'd0);
        chk("rst_cnt_s", 32'(stall_count_s), 32'd0);
        idle(); step();

        // Randomized traffic checked by the per-cycle compare
        for (int n = 0; n < 3000; n++) begin
            rst_n       = ($urandom_range(0, 199) != 0);
            id_valid    = ($urandom_range(0, 4) != 0);
            id_rd       = 4'($urandom_range(0, 7));
            id_regwrite = ($urandom_range(0, 4) != 0);
            id_is_load  = ($urandom_range(0, 2) == 0);
            id_src      = {4'($urandom_range(0, 7)), 4'($urandom_range(0, 7))};
            flush       = ($urandom_range(0, 9) == 0);
            ext_stall   = ($urandom_range(0, 7) == 0);
            step();
        end
        rst_n = 1;
        idle();
        step();
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
